// File: rtl/cnn_pkg.sv
// cnn_pkg: sequencer state/job types and the per-layer network table
package cnn_pkg;
    localparam int LAYER_W = 3;
    localparam int IDX_W = 7;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic {JOB_CONV = 1'b0, JOB_POOL = 1'b1} job_kind_t;
    typedef struct packed {
        logic [IDX_W-1:0] nf;
        logic [IDX_W-1:0] nc;
        logic [IDX_W-1:0] nm;
        logic [5:0]       map_size;
    } layer_cfg_t;
    // Entries 6 and 7 pad the table to the full layer index range.
    localparam layer_cfg_t LAYER_TABLE [8] = '{
        '{7'd6,   7'd1,  7'd0,   6'd28},
        '{7'd0,   7'd0,  7'd6,   6'd14},
        '{7'd16,  7'd6,  7'd0,   6'd10},
        '{7'd0,   7'd0,  7'd16,  6'd5},
        '{7'd120, 7'd16, 7'd0,   6'd1},
        '{7'd0,   7'd0,  7'd120, 6'd1},
        '{7'd1,   7'd1,  7'd1,   6'd1},
        '{7'd1,   7'd1,  7'd1,   6'd1}
    };
endpackage

// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: job descriptor handshake between sequencer and engine
interface layer_sequencer_if;
    logic                     job_valid;
    logic                     job_ready;
    cnn_pkg::job_kind_t       job_kind;
    logic [cnn_pkg::LAYER_W-1:0] job_layer;
    logic [cnn_pkg::IDX_W-1:0]   job_out_idx;
    logic [cnn_pkg::IDX_W-1:0]   job_in_idx;
    logic                     job_accum;
    logic                     eng_done;
    modport master (
        output job_valid, job_kind, job_layer, job_out_idx, job_in_idx, job_accum,
        input  job_ready, eng_done
    );
    modport slave (
        input  job_valid, job_kind, job_layer, job_out_idx, job_in_idx, job_accum,
        output job_ready, eng_done
    );
endinterface

// File: rtl/layer_index_counter.sv
// layer_index_counter: nested out/in job counters with a last-job-of-layer flag
module layer_index_counter
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  job_kind_t        kind,
    input  logic [IDX_W-1:0] nf,
    input  logic [IDX_W-1:0] nc,
    input  logic [IDX_W-1:0] nm,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] in_idx,
    output logic             last
);
    logic [IDX_W-1:0] out_q, in_q;
    logic in_last, out_last;
    // pool layers have no inner loop, so the in index mirrors the out index
    always_comb begin
        in_last = (kind == JOB_POOL) || (in_q == nc - 7'd1);
        out_last = out_q == ((kind == JOB_POOL) ? nm : nf) - 7'd1;
        last = in_last && out_last;
        out_idx = out_q;
        in_idx = (kind == JOB_POOL) ? out_q : in_q;
    end
    // the last job of a layer returns both counters to zero for the next layer
    always_ff @(posedge clk) begin
        if (rst || clr || (adv && last)) begin
            out_q <= '0;
            in_q <= '0;
        end else if (adv) begin
            out_q <= in_last ? out_q + 7'd1 : out_q;
            in_q <= in_last ? '0 : in_q + 7'd1;
        end
    end
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: walks CNN layers issuing one job at a time; LAYER_SEQ_PERF_EN adds perf_cycles
module layer_sequencer
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    layer_sequencer_if.master bus,
    output logic busy,
    output logic finish
`ifdef LAYER_SEQ_PERF_EN
    ,
    output logic [31:0] perf_cycles
`endif
);
    state_t state_q, state_d;
    logic [LAYER_W-1:0] layer_q;
    logic clr, adv, last, final_layer;
    job_kind_t kind;
    logic [IDX_W-1:0] out_idx, in_idx;

    assign kind = job_kind_t'(layer_q[0]);
    assign final_layer = layer_q == LAYER_W'(NUM_LAYERS - 1);

    layer_index_counter u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .adv(adv),
        .kind(kind),
        .nf(LAYER_TABLE[layer_q].nf),
        .nc(LAYER_TABLE[layer_q].nc),
        .nm(LAYER_TABLE[layer_q].nm),
        .out_idx(out_idx),
        .in_idx(in_idx),
        .last(last)
    );

    // state register
    always_ff @(posedge clk) begin
        state_q <= rst ? S_IDLE : state_d;
    end

    // next state; counters clear on an accepted start and advance on eng_done in WAIT
    always_comb begin
        state_d = state_q;
        clr = 1'b0;
        adv = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                clr = start;
                state_d = start ? S_ISSUE : state_q;
            end
            S_ISSUE: state_d = bus.job_ready ? S_WAIT : S_ISSUE;
            S_WAIT: begin
                adv = bus.eng_done;
                state_d = !bus.eng_done ? S_WAIT : (last && final_layer) ? S_DONE : S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // layer index steps only when a non-final layer completes
    always_ff @(posedge clk) begin
        if (rst || clr) layer_q <= '0;
        else if (adv && last && !final_layer) layer_q <= layer_q + 3'd1;
    end

    assign bus.job_valid = state_q == S_ISSUE;
    assign bus.job_kind = kind;
    assign bus.job_layer = layer_q;
    assign bus.job_out_idx = out_idx;
    assign bus.job_in_idx = in_idx;
    assign bus.job_accum = (kind == JOB_CONV) && (in_idx != '0);
    assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign finish = state_q == S_DONE;

`ifdef LAYER_SEQ_PERF_EN
    // busy-cycle counter; restarts with each accepted start and freezes once DONE
    always_ff @(posedge clk) begin
        if (rst || clr) perf_cycles <= '0;
        else if (busy) perf_cycles <= perf_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed self-checking bench for layer_sequencer
module tb_layer_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, finish;
`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] perf_cycles;
`endif
    int checks = 0;
    int failures = 0;
    int nf_t [6] = '{6, 0, 16, 0, 120, 0};
    int nc_t [6] = '{1, 0, 6, 0, 16, 0};
    int nm_t [6] = '{0, 6, 0, 16, 0, 120};
    int exp_cnt [6] = '{6, 6, 96, 16, 1920, 120};
    int lay_cnt [6] = '{0, 0, 0, 0, 0, 0};
    int el, eo, ei, dones, cyc, busy_cnt;

    layer_sequencer_if bus();

    layer_sequencer #(.NUM_LAYERS(6)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus),
        .busy(busy),
        .finish(finish)
`ifdef LAYER_SEQ_PERF_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack(input int l, input int o, input int i, input logic a, input logic k);
        return {13'd0, 3'(l), 7'(o), 7'(i), a, k};
    endfunction

    function automatic logic [31:0] desc();
        return {13'd0, bus.job_layer, bus.job_out_idx, bus.job_in_idx, bus.job_accum, bus.job_kind};
    endfunction

    initial begin
        bus.job_ready = 1'b1;
        bus.eng_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", bus.job_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_finish", finish, 1'b0);
        check("rst_desc", desc(), 32'd0);

        // full run with a zero-delay engine
        start = 1'b1;
        tick();
        start = 1'b0;
        check("valid_after_start", bus.job_valid, 1'b1);
        el = 0; eo = 0; ei = 0; dones = 0; cyc = 0; busy_cnt = 0;
        while (!finish && cyc < 10000) begin
            if (busy) busy_cnt++;
            bus.eng_done = busy && !bus.job_valid;
            if (bus.job_valid && bus.job_ready) begin
                if (el < 6) begin
                    check("desc", desc(), pack(el, eo, (el % 2 == 0) ? ei : eo, (el % 2 == 0) && (ei != 0), el % 2 == 1));
                    lay_cnt[el]++;
                    if (el % 2 == 0) begin
                        ei++;
                        if (ei == nc_t[el]) begin
                            ei = 0;
                            eo++;
                            if (eo == nf_t[el]) begin eo = 0; el++; end
                        end
                    end else begin
                        eo++;
                        if (eo == nm_t[el]) begin eo = 0; el++; end
                    end
                end else begin
                    check("extra_job", el, 5);
                end
            end
            if (bus.eng_done) dones++;
            tick();
            cyc++;
        end
        bus.eng_done = 1'b0;
        check("finish_seen", finish, 1'b1);
        check("dones_at_finish", dones, 2164);
        check("busy_cycles", busy_cnt, 4328);
        for (int l = 0; l < 6; l++) check($sformatf("jobs_l%0d", l), lay_cnt[l], exp_cnt[l]);
        check("done_busy", busy, 1'b0);
        check("done_valid", bus.job_valid, 1'b0);
`ifdef LAYER_SEQ_PERF_EN
        check("perf_run", perf_cycles, busy_cnt);
`endif
        tick();
        tick();
        tick();
        check("finish_held", finish, 1'b1);
`ifdef LAYER_SEQ_PERF_EN
        check("perf_frozen", perf_cycles, 32'd4328);
`endif

        // restart from DONE with the engine stalling, plus ignored start/eng_done
        bus.job_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_finish", finish, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.eng_done = (i == 3);
            start = (i == 6);
            tick();
            check("stall_valid", bus.job_valid, 1'b1);
            check("stall_desc", desc(), pack(0, 0, 0, 1'b0, 1'b0));
        end
        bus.eng_done = 1'b0;
        start = 1'b0;
        bus.job_ready = 1'b1;
        tick();
        check("wait_valid", bus.job_valid, 1'b0);
        check("wait_busy", busy, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wait_start_ignored", {bus.job_valid, busy}, 2'b01);
        check("wait_desc", desc(), pack(0, 0, 0, 1'b0, 1'b0));
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        check("next_valid", bus.job_valid, 1'b1);
        check("next_desc", desc(), pack(0, 1, 0, 1'b0, 1'b0));

        // run into L2 WAIT (out0,in3), then reset mid-run
        cyc = 0;
        while (!(busy && !bus.job_valid && bus.job_layer == 3'd2 && bus.job_in_idx == 7'd3) && cyc < 200) begin
            bus.eng_done = busy && !bus.job_valid;
            tick();
            cyc++;
        end
        check("reach_l2_wait", cyc < 200, 1'b1);
        bus.eng_done = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", bus.job_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_finish", finish, 1'b0);
        check("midrst_desc", desc(), 32'd0);
`ifdef LAYER_SEQ_PERF_EN
        check("midrst_perf", perf_cycles, 32'd0);
`endif
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        check("stray_done_busy", busy, 1'b0);
        check("stray_done_desc", desc(), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_valid", bus.job_valid, 1'b1);
        check("rerun_desc", desc(), pack(0, 0, 0, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter NUM_LAYERS, default 6, number of layers walked per run; even layers are convolution, odd layers are pooling.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 job_valid  output  1  job descriptor valid.
REQ-006 job_ready  input  1  engine accepts descriptor.
REQ-007 job_kind  output  1  0 = conv, 1 = pool.
REQ-008 job_layer  output  3  current layer index.
REQ-009 job_out_idx  output  7  conv filter index or pooled map index.
REQ-010 job_in_idx  output  7  conv input-map index; equals job_out_idx for pool.
REQ-011 job_accum  output  1  conv only: 1 = add to stored partial sum, 0 = overwrite.
REQ-012 eng_done  input  1  one-cycle pulse; the outstanding job has completed.
REQ-013 busy  output  1  high outside IDLE and DONE.
REQ-014 finish  output  1  run complete.

Function
REQ-015 States: IDLE, ISSUE, WAIT, DONE; single outstanding job, no pipelining of jobs.
REQ-016 IDLE: start=1 -> ISSUE with layer=0, out=0, in=0; job_valid rises the cycle after start is sampled.
REQ-017 ISSUE: job_valid=1; descriptor fields stable until job_valid&&job_ready; handshake -> WAIT.
REQ-018 WAIT: job_valid=0; eng_done -> advance indices, then ISSUE (job_valid next cycle) or DONE if the last job of the last layer completed.
REQ-019 Conv layer order: outer loop over filters 0..NF-1, inner loop over input maps 0..NC-1; job_accum = (in_idx != 0).
REQ-020 Pool layer order: maps 0..NM-1, one job each; job_accum = 0.
REQ-021 Layer advance: after the last job of a layer, layer increments and out/in reset to 0.
REQ-022 DONE: finish=1, held until the cycle after a new start is sampled; start in DONE behaves as in IDLE.
REQ-023 start outside IDLE/DONE is ignored; eng_done outside WAIT is ignored; job_ready without job_valid is ignored.
REQ-024 eng_done and job_ready asserted together in WAIT: eng_done is processed; job_ready has no effect.
REQ-025 Counters never wrap; index widths cover the package table maxima.

Reset
REQ-026 rst=1 forces IDLE in any state, including mid-run; outputs job_valid=0, busy=0, finish=0, and all descriptor fields 0 on the next edge.
REQ-027 After reset, eng_done from a previously issued job is ignored.

Configuration
REQ-028 LAYER_SEQ_PERF_EN defined: adds output perf_cycles (32 bits), cleared when start is accepted, incrementing each cycle while busy=1, and frozen in DONE. Not defined: the port and counter are absent; behaviour is otherwise identical.

Structure
REQ-029 Shared package cnn_pkg holds the state enum, the job_kind_t enum, and the per-layer table (NF, NC, NM, map size).
REQ-030 Default table: L0 conv NF=6 NC=1; L1 pool NM=6; L2 conv NF=16 NC=6; L3 pool NM=16; L4 conv NF=120 NC=16; L5 pool NM=120.
REQ-031 One sub-module, layer_index_counter, implements nested out/in counters with a last-job flag; the FSM is in the top module.

Verification
REQ-032 Reset then start with a zero-delay engine (ready=1, done one cycle after the handshake): job counts per layer are 6, 6, 96, 16, 1920, 120 (total 2164), and finish rises after the 2164th eng_done.
REQ-033 L2 descriptor sequence begins (out0,in0,accum0), (out0,in1,accum1) ... (out0,in5,accum1), (out1,in0,accum0).
REQ-034 Hold job_ready=0 for 10 cycles in ISSUE: job_valid stays 1 and the fields do not change; no WAIT entry occurs.
REQ-035 Assert rst during WAIT in L2: the next cycle shows IDLE with all outputs 0; a stray eng_done is ignored; a new start restarts at L0 (out0,in0).
REQ-036 Pulse start mid-run, and eng_done during ISSUE: there is no state, index, or counter change.
REQ-037 With LAYER_SEQ_PERF_EN and the REQ-032 engine: perf_cycles equals the busy-cycle count and holds in DONE.
